// File: rtl/vc_router_param.sv
// NUM_VC virtual-channel FIFOs steered by a header VC field and arbitrated onto NUM_DEST ports.
// Define VCR_STRICT_PRIO_EN for fixed lowest-index priority; otherwise round robin.
module vc_router_param #(
   parameter int DATA_W   = 6,
   parameter int NUM_VC   = 2,
   parameter int NUM_DEST = 2,
   parameter int DEPTH    = 4,
   localparam int VCW     = $clog2(NUM_VC),
   localparam int DW      = $clog2(NUM_DEST),
   localparam int AW      = $clog2(DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       init,
   input  logic [AW-1:0]              af_thr_i,
   input  logic [AW-1:0]              ae_thr_i,
   input  logic                       push_in,
   input  logic [DATA_W-1:0]          data_in,
   input  logic [NUM_DEST-1:0]        pause_dest_i,
   output logic                       pause_o,
   output logic [NUM_DEST-1:0]        valid_out,
   output logic [NUM_DEST*DATA_W-1:0] data_out,
   output logic [NUM_VC-1:0]          error_out,
   output logic                       active_out,
   output logic                       idle_out
);
   localparam int            PW     = $clog2(DEPTH);
   localparam logic [AW-1:0] FULL   = AW'(DEPTH);
   localparam logic [AW-1:0] AF_DEF = AW'(DEPTH - 1);
   localparam logic [AW-1:0] AE_DEF = AW'(1);

   typedef enum logic [1:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE} state_t;
   state_t state, state_nxt;

   logic [DATA_W-1:0]   mem       [NUM_VC][DEPTH];
   logic [PW-1:0]       rd_ptr    [NUM_VC];
   logic [PW-1:0]       wr_ptr    [NUM_VC];
   logic [AW-1:0]       count     [NUM_VC];
   logic [AW-1:0]       count_nxt [NUM_VC];
   logic [NUM_VC-1:0]   nonempty, eligible, pop, push_ok, ovf, pause_q, pause_nxt, err_q;
   logic [AW-1:0]       af_thr, ae_thr;
   logic                running, thr_ok, vld_p0;
   logic [VCW-1:0]      push_vc, grant_vc;
   logic [DATA_W-1:0]   word_p0;
   logic [DW-1:0]       dest_p0;
   logic [NUM_DEST-1:0] onehot_p0;
`ifndef VCR_STRICT_PRIO_EN
   logic [VCW-1:0]      last_grant, rr_idx;
`endif

   assign running   = (state == S_IDLE) || (state == S_ACTIVE);
   assign push_vc   = data_in[DATA_W-1 -: VCW];
   assign thr_ok    = (af_thr_i != '0) && (af_thr_i <= FULL) && (ae_thr_i < af_thr_i);
   assign pause_o   = |pause_q;
   assign error_out = err_q;

   // stage p0: head eligibility and single-winner grant
   always_comb begin
      for (int v = 0; v < NUM_VC; v++) begin
         nonempty[v] = (count[v] != '0);
         eligible[v] = nonempty[v] && !pause_dest_i[mem[v][rd_ptr[v]][DATA_W-VCW-1 -: DW]];
      end
      vld_p0   = 1'b0;
      grant_vc = '0;
`ifdef VCR_STRICT_PRIO_EN
      for (int k = NUM_VC - 1; k >= 0; k--) begin
         if (running && eligible[k]) begin
            vld_p0   = 1'b1;
            grant_vc = VCW'(k);
         end
      end
`else
      // Walk from lowest to highest priority so the entry just after last_grant wins.
      rr_idx = '0;
      for (int k = NUM_VC; k >= 1; k--) begin
         rr_idx = last_grant + VCW'(k);
         if (running && eligible[rr_idx]) begin
            vld_p0   = 1'b1;
            grant_vc = rr_idx;
         end
      end
`endif
      word_p0 = mem[grant_vc][rd_ptr[grant_vc]];
      dest_p0 = word_p0[DATA_W-VCW-1 -: DW];
      for (int d = 0; d < NUM_DEST; d++)
         onehot_p0[d] = vld_p0 && (dest_p0 == DW'(d));
   end

   always_comb begin
      for (int v = 0; v < NUM_VC; v++) begin
         pop[v]       = vld_p0 && (grant_vc == VCW'(v));
         push_ok[v]   = running && push_in && (push_vc == VCW'(v)) && ((count[v] != FULL) || pop[v]);
         ovf[v]       = running && push_in && (push_vc == VCW'(v)) && (count[v] == FULL) && !pop[v];
         count_nxt[v] = count[v] + AW'(push_ok[v]) - AW'(pop[v]);
         // Hysteresis: between the two thresholds the flag keeps its value.
         if (count_nxt[v] >= af_thr)
            pause_nxt[v] = 1'b1;
         else if (count_nxt[v] <= ae_thr)
            pause_nxt[v] = 1'b0;
         else
            pause_nxt[v] = pause_q[v];
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_RESET:  if (init) state_nxt = S_INIT;
         S_INIT:   if (!init) state_nxt = S_IDLE;
         S_IDLE:   if (init) state_nxt = S_INIT;
                   else if (|nonempty) state_nxt = S_ACTIVE;
         S_ACTIVE: if (init) state_nxt = S_INIT;
                   else if (!(|nonempty) && (valid_out == '0)) state_nxt = S_IDLE;
         default:  state_nxt = S_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      for (int v = 0; v < NUM_VC; v++)
         if (push_ok[v]) mem[v][wr_ptr[v]] <= data_in;
   end

   // stage p1: registered grant, FIFO control and status
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_RESET;
         active_out <= 1'b0;
         idle_out   <= 1'b0;
         for (int v = 0; v < NUM_VC; v++) begin
            rd_ptr[v] <= '0;
            wr_ptr[v] <= '0;
            count[v]  <= '0;
         end
         pause_q    <= '0;
         err_q      <= '0;
         af_thr     <= AF_DEF;
         ae_thr     <= AE_DEF;
`ifndef VCR_STRICT_PRIO_EN
         last_grant <= '0;
`endif
         valid_out  <= '0;
         data_out   <= '0;
      end else begin
         state      <= state_nxt;
         active_out <= (state_nxt == S_ACTIVE);
         idle_out   <= (state_nxt == S_IDLE);
         for (int v = 0; v < NUM_VC; v++) begin
            if (pop[v])     rd_ptr[v] <= rd_ptr[v] + PW'(1);
            if (push_ok[v]) wr_ptr[v] <= wr_ptr[v] + PW'(1);
            count[v] <= count_nxt[v];
         end
         pause_q <= pause_nxt;
         err_q   <= (state_nxt == S_INIT) ? '0 : (err_q | ovf);
         if (state == S_INIT) begin
            af_thr <= thr_ok ? af_thr_i : AF_DEF;
            ae_thr <= thr_ok ? ae_thr_i : AE_DEF;
         end
`ifndef VCR_STRICT_PRIO_EN
         if (vld_p0) last_grant <= grant_vc;
`endif
         valid_out <= onehot_p0;
         for (int d = 0; d < NUM_DEST; d++)
            if (onehot_p0[d]) data_out[d*DATA_W +: DATA_W] <= word_p0;
      end
   end

endmodule

// File: tb/tb_vc_router_param.sv
// Bench for vc_router_param (DATA_W=6, 2 VCs, 2 destinations, DEPTH=4): vector table,
// directed corner sequences, then random traffic against a queue-based reference model.
module tb_vc_router_param;
   logic        clk = 1'b0;
   logic        reset, init, push_in;
   logic [2:0]  af_thr_i, ae_thr_i;
   logic [5:0]  data_in;
   logic [1:0]  pause_dest_i;
   logic        pause_o, active_out, idle_out;
   logic [1:0]  valid_out, error_out;
   logic [11:0] data_out;

   int vectors = 0;
   int miscompares = 0;

   vc_router_param #(.DATA_W(6), .NUM_VC(2), .NUM_DEST(2), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .init(init), .af_thr_i(af_thr_i), .ae_thr_i(ae_thr_i),
      .push_in(push_in), .data_in(data_in), .pause_dest_i(pause_dest_i), .pause_o(pause_o),
      .valid_out(valid_out), .data_out(data_out), .error_out(error_out),
      .active_out(active_out), .idle_out(idle_out));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string t, input logic [1:0] ev, input logic [5:0] e0, input logic [5:0] e1,
                          input logic ep, input logic [1:0] ee, input logic ea, input logic ei);
      chk({t, " valid"}, 12'(valid_out), 12'(ev));
      if (ev[0]) chk({t, " data0"}, 12'(data_out[5:0]), 12'(e0));
      if (ev[1]) chk({t, " data1"}, 12'(data_out[11:6]), 12'(e1));
      chk({t, " pause"}, 12'(pause_o), 12'(ep));
      chk({t, " error"}, 12'(error_out), 12'(ee));
      chk({t, " active"}, 12'(active_out), 12'(ea));
      chk({t, " idle"}, 12'(idle_out), 12'(ei));
   endtask

   // ---------------- reference model: per-VC queues and plain rules ----------------
   logic [5:0] mq [2][$];
   int         mst;          // 0 reset, 1 init, 2 idle, 3 active
   logic [2:0] maf, mae;
   logic [1:0] mpf, merr, mval;
   logic [5:0] mdat [2];
   int         mlast;

   task automatic model_reset();
      mq[0].delete(); mq[1].delete();
      mst = 0; maf = 3; mae = 1; mpf = '0; merr = '0; mval = '0;
      mdat[0] = '0; mdat[1] = '0; mlast = 0;
   endtask

   task automatic model_step(input logic i_init, input logic [2:0] i_af, input logic [2:0] i_ae,
                             input logic i_push, input logic [5:0] i_din, input logic [1:0] i_pd);
      int g, nst, sz0, sz1, v;
      logic [5:0] h, w;
      logic [1:0] pre_val;
      bit run;
      run = (mst >= 2);
      sz0 = mq[0].size(); sz1 = mq[1].size();
      pre_val = mval;
      g = -1;
      if (run) begin
         for (int k = 0; k < 2; k++) begin
`ifdef VCR_STRICT_PRIO_EN
            v = k;
`else
            v = (mlast + 1 + k) % 2;
`endif
            if (g < 0 && mq[v].size() > 0) begin
               h = mq[v][0];
               if (!i_pd[h[4]]) g = v;
            end
         end
      end
      mval = '0;
      if (g >= 0) begin
         w = mq[g].pop_front();
         mval[w[4]] = 1'b1;
         mdat[w[4]] = w;
         mlast = g;
      end
      if (run && i_push) begin
         v = int'(i_din[5]);
         if (mq[v].size() < 4) mq[v].push_back(i_din);
         else merr[v] = 1'b1;
      end
      for (int q = 0; q < 2; q++) begin
         if (mq[q].size() >= int'(maf)) mpf[q] = 1'b1;
         else if (mq[q].size() <= int'(mae)) mpf[q] = 1'b0;
      end
      case (mst)
         0: nst = i_init ? 1 : 0;
         1: nst = i_init ? 1 : 2;
         2: nst = i_init ? 1 : ((sz0 + sz1 > 0) ? 3 : 2);
         default: nst = i_init ? 1 : ((sz0 + sz1 == 0 && pre_val == 0) ? 2 : 3);
      endcase
      if (mst == 1) begin
         if (i_af == 0 || i_af > 4 || i_ae >= i_af) begin maf = 3; mae = 1; end
         else begin maf = i_af; mae = i_ae; end
      end
      if (nst == 1) merr = '0;
      mst = nst;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic       init;
      logic [2:0] af, ae;
      logic       push;
      logic [5:0] din;
      logic [1:0] pd;
      logic [1:0] ev;
      logic [5:0] ed;
      logic       ep;
      logic [1:0] ee;
      logic       ea, ei;
   } vec_t;

   vec_t       tbl [17];
   logic [5:0] order [4];

   initial begin
      reset = 1'b1; init = 1'b0; push_in = 1'b0; af_thr_i = 3'd3; ae_thr_i = 3'd1;
      data_in = '0; pause_dest_i = '0;

      //        init af ae push din    pd       ev     ed    ep ee     ea ei
      tbl[0]  = '{1'b1, 3'd3, 3'd1, 1'b0, 6'h00, 2'b00, 2'b00, 6'h00, 1'b0, 2'b00, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 3'd3, 3'd1, 1'b0, 6'h00, 2'b00, 2'b00, 6'h00, 1'b0, 2'b00, 1'b0, 1'b1};
      tbl[2]  = '{1'b0, 3'd3, 3'd1, 1'b1, 6'h05, 2'b00, 2'b00, 6'h00, 1'b0, 2'b00, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 3'd3, 3'd1, 1'b0, 6'h00, 2'b00, 2'b01, 6'h05, 1'b0, 2'b00, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 3'd3, 3'd1, 1'b0, 6'h00, 2'b00, 2'b00, 6'h00, 1'b0, 2'b00, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 3'd3, 3'd1, 1'b0, 6'h00, 2'b00, 2'b00, 6'h00, 1'b0, 2'b00, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 3'd3, 3'd1, 1'b1, 6'h01, 2'b11, 2'b00, 6'h00, 1'b0, 2'b00, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 3'd3, 3'd1, 1'b1, 6'h02, 2'b11, 2'b00, 6'h00, 1'b0, 2'b00, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 3'd3, 3'd1, 1'b1, 6'h03, 2'b11, 2'b00, 6'h00, 1'b1, 2'b00, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 3'd3, 3'd1, 1'b1, 6'h04, 2'b11, 2'b00, 6'h00, 1'b1, 2'b00, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 3'd3, 3'd1, 1'b1, 6'h06, 2'b11, 2'b00, 6'h00, 1'b1, 2'b01, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 3'd3, 3'd1, 1'b0, 6'h00, 2'b00, 2'b01, 6'h01, 1'b1, 2'b01, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 3'd3, 3'd1, 1'b0, 6'h00, 2'b00, 2'b01, 6'h02, 1'b1, 2'b01, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 3'd3, 3'd1, 1'b0, 6'h00, 2'b00, 2'b01, 6'h03, 1'b0, 2'b01, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 3'd3, 3'd1, 1'b0, 6'h00, 2'b00, 2'b01, 6'h04, 1'b0, 2'b01, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 3'd3, 3'd1, 1'b0, 6'h00, 2'b00, 2'b00, 6'h00, 1'b0, 2'b01, 1'b1, 1'b0};
      tbl[16] = '{1'b0, 3'd3, 3'd1, 1'b0, 6'h00, 2'b00, 2'b00, 6'h00, 1'b0, 2'b01, 1'b0, 1'b1};

`ifdef VCR_STRICT_PRIO_EN
      order[0] = 6'h01; order[1] = 6'h02; order[2] = 6'h21; order[3] = 6'h22;
`else
      order[0] = 6'h01; order[1] = 6'h21; order[2] = 6'h02; order[3] = 6'h22;
`endif

      step();
      chk("reset data", data_out, 12'h000);
      chk_out("reset", 2'b00, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < 17; i++) begin
         init = tbl[i].init; af_thr_i = tbl[i].af; ae_thr_i = tbl[i].ae;
         push_in = tbl[i].push; data_in = tbl[i].din; pause_dest_i = tbl[i].pd;
         step();
         chk_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].ed, 6'h00, tbl[i].ep, tbl[i].ee, tbl[i].ea, tbl[i].ei);
      end
      push_in = 1'b0;

      // re-init clears the sticky error
      init = 1'b1; step();
      chk("init err clr", 12'(error_out), 12'h0);
      init = 1'b0; step();
      chk("reinit idle", 12'(idle_out), 12'h1);

      // arbitration order: a single VC1 grant first so the last grant is VC1
      pause_dest_i = 2'b00; push_in = 1'b1; data_in = 6'h21; step();
      push_in = 1'b0; step();
      chk("rr warm valid", 12'(valid_out), 12'h1);
      chk("rr warm data", 12'(data_out[5:0]), 12'h21);
      step(); step(); step();
      pause_dest_i = 2'b01;
      data_in = 6'h01; push_in = 1'b1; step();
      data_in = 6'h02; step();
      data_in = 6'h21; step();
      data_in = 6'h22; step();
      push_in = 1'b0; pause_dest_i = 2'b00;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("arb%0d valid", i), 12'(valid_out), 12'h1);
         chk($sformatf("arb%0d data", i), 12'(data_out[5:0]), 12'(order[i]));
      end
      step();
      chk("arb drained", 12'(valid_out), 12'h0);

      // blocked VC0 head must not stall VC1
      pause_dest_i = 2'b01;
      push_in = 1'b1; data_in = 6'h03; step();
      data_in = 6'h31; step();
      push_in = 1'b0; step();
      chk("hol valid", 12'(valid_out), 12'h2);
      chk("hol data1", 12'(data_out[11:6]), 12'h31);
      step();
      chk("hol held a", 12'(valid_out), 12'h0);
      step();
      chk("hol held b", 12'(valid_out), 12'h0);
      pause_dest_i = 2'b00; step();
      chk("hol rel valid", 12'(valid_out), 12'h1);
      chk("hol rel data0", 12'(data_out[5:0]), 12'h03);
      step(); step();

      // valid 4/2 first, then invalid af=0 must fall back to 3/1
      init = 1'b1; af_thr_i = 3'd4; ae_thr_i = 3'd2; step();
      step();
      init = 1'b0; af_thr_i = 3'd0; ae_thr_i = 3'd2; step();
      chk("thr idle", 12'(idle_out), 12'h1);
      pause_dest_i = 2'b11; push_in = 1'b1;
      data_in = 6'h0A; step(); chk("thr p1", 12'(pause_o), 12'h0);
      data_in = 6'h0B; step(); chk("thr p2", 12'(pause_o), 12'h0);
      data_in = 6'h0C; step(); chk("thr p3", 12'(pause_o), 12'h1);
      push_in = 1'b0; pause_dest_i = 2'b00;
      step(); chk("thr hold", 12'(pause_o), 12'h1); chk("thr d0", 12'(data_out[5:0]), 12'h0A);
      step(); chk("thr clear", 12'(pause_o), 12'h0); chk("thr d1", 12'(data_out[5:0]), 12'h0B);
      step(); chk("thr d2", 12'(data_out[5:0]), 12'h0C);
      step(); step();

      // asynchronous reset with words queued
      af_thr_i = 3'd3; ae_thr_i = 3'd1; pause_dest_i = 2'b01; push_in = 1'b1;
      data_in = 6'h01; step();
      data_in = 6'h02; step();
      data_in = 6'h03; step();
      data_in = 6'h31; step();
      push_in = 1'b0; step();
      chk("pre-rst valid", 12'(valid_out), 12'h2);
      chk("pre-rst pause", 12'(pause_o), 12'h1);
      #1 reset = 1'b1;
      #1;
      chk("rst data", data_out, 12'h000);
      chk_out("rst async", 2'b00, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0, 1'b0);
      step();
      reset = 1'b0;
      init = 1'b1; step();
      init = 1'b0; pause_dest_i = 2'b00; step();
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("no stale %0d", i), 12'(valid_out), 12'h0);
      end
      chk("post-rst idle", 12'(idle_out), 12'h1);

      // random traffic against the reference model
      reset = 1'b1; step();
      reset = 1'b0;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         init         = (c < 2) || ($urandom_range(0, 39) == 0);
         af_thr_i     = 3'($urandom_range(0, 7));
         ae_thr_i     = 3'($urandom_range(0, 7));
         push_in      = ($urandom_range(0, 9) < 7);
         data_in      = 6'($urandom);
         pause_dest_i = 2'($urandom_range(0, 3));
         model_step(init, af_thr_i, ae_thr_i, push_in, data_in, pause_dest_i);
         step();
         chk_out("rnd", mval, mdat[0], mdat[1], |mpf, merr, (mst == 3), (mst == 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
